// File: rtl/laser_pulse_guard_mc.sv
// rtl/laser_pulse_guard_mc.sv - multi-channel laser pulse width/rate guard
// Per-channel sync + edge detect + FSM; sticky fault flags feed a registered shutdown.
module laser_pulse_guard_mc #(
  parameter int NCH         = 4,
  parameter int CNT_W       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NCH-1:0]   laser_pulse,
  input  logic [NCH-1:0]   chan_enable,
  input  logic [NCH-1:0]   clear_fail,
  input  logic [CNT_W-1:0] width_lo_limit,
  input  logic [CNT_W-1:0] width_hi_limit,
  input  logic [CNT_W-1:0] period_lo_limit,
  output logic [NCH-1:0]   pulse_lower_fail,
  output logic [NCH-1:0]   pulse_upper_fail,
  output logic [NCH-1:0]   rate_fail,
  output logic             shutdown,
  output logic [7:0]       fail_event_cnt
);

  typedef enum logic [1:0] {ST_DISABLED, ST_ARMED, ST_HIGH, ST_LOW} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_ONE;
  endfunction

  logic [NCH-1:0] lower_fault;
  logic [NCH-1:0] upper_fault;
  logic [NCH-1:0] rate_fault;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   fall;
    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       wcnt;
    logic [CNT_W-1:0]       wcnt_nxt;
    logic [CNT_W-1:0]       pcnt;
    logic [CNT_W-1:0]       pcnt_nxt;
    logic                   lf;
    logic                   uf;
    logic                   rf;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sync  <= '0;
        s_d   <= 1'b0;
        state <= ST_ARMED;
        wcnt  <= '0;
        pcnt  <= '0;
      end else begin
        sync  <= {sync[SYNC_STAGES-2:0], laser_pulse[i]};
        s_d   <= s;
        state <= state_nxt;
        wcnt  <= wcnt_nxt;
        pcnt  <= pcnt_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      pcnt_nxt  = pcnt;
      lf        = 1'b0;
      uf        = 1'b0;
      rf        = 1'b0;
      if (!chan_enable[i]) begin
        state_nxt = ST_DISABLED;
        wcnt_nxt  = '0;
        pcnt_nxt  = '0;
      end else begin
        case (state)
          ST_DISABLED: state_nxt = ST_ARMED;
          ST_ARMED: begin
            // First rise only starts the counters; there is no prior edge to rate-check.
            if (rise) begin
              state_nxt = ST_HIGH;
              wcnt_nxt  = CNT_ONE;
              pcnt_nxt  = CNT_ONE;
            end
          end
          ST_HIGH: begin
            pcnt_nxt = sat_inc(pcnt);
            if (fall) begin
              state_nxt = ST_LOW;
              lf        = (wcnt < width_lo_limit);
            end else if (s) begin
              wcnt_nxt = sat_inc(wcnt);
              uf       = (width_hi_limit != '0) && (wcnt == width_hi_limit);
            end
          end
          ST_LOW: begin
            if (rise) begin
              state_nxt = ST_HIGH;
              rf        = (pcnt < period_lo_limit);
              wcnt_nxt  = CNT_ONE;
              pcnt_nxt  = CNT_ONE;
            end else begin
              pcnt_nxt = sat_inc(pcnt);
            end
          end
          default: state_nxt = ST_ARMED;
        endcase
      end
    end

    assign lower_fault[i] = lf;
    assign upper_fault[i] = uf;
    assign rate_fault[i]  = rf;
  end

  logic [NCH-1:0]   lower_nxt;
  logic [NCH-1:0]   upper_nxt;
  logic [NCH-1:0]   rate_nxt;
  logic [3*NCH-1:0] new_set;
  logic [15:0]      evt_sum;
  logic [7:0]       evt_nxt;

  // A fault in the same cycle as its clear keeps the flag set.
  always_comb begin
    lower_nxt = lower_fault | (pulse_lower_fail & ~clear_fail);
    upper_nxt = upper_fault | (pulse_upper_fail & ~clear_fail);
    rate_nxt  = rate_fault  | (rate_fail        & ~clear_fail);
    new_set   = {lower_nxt & ~pulse_lower_fail,
                 upper_nxt & ~pulse_upper_fail,
                 rate_nxt  & ~rate_fail};
    evt_sum   = {8'd0, fail_event_cnt};
    for (int j = 0; j < 3*NCH; j++) begin
      evt_sum = evt_sum + 16'(new_set[j]);
    end
    evt_nxt = (evt_sum > 16'd255) ? 8'hff : evt_sum[7:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pulse_lower_fail <= '0;
      pulse_upper_fail <= '0;
      rate_fail        <= '0;
      shutdown         <= 1'b0;
      fail_event_cnt   <= '0;
    end else begin
      pulse_lower_fail <= lower_nxt;
      pulse_upper_fail <= upper_nxt;
      rate_fail        <= rate_nxt;
      shutdown         <= |{pulse_lower_fail, pulse_upper_fail, rate_fail};
      fail_event_cnt   <= evt_nxt;
    end
  end

endmodule

// File: tb/tb_laser_pulse_guard_mc.sv
// tb/tb_laser_pulse_guard_mc.sv - scoreboard bench for laser_pulse_guard_mc
// Driver pushes expected output snapshots with their edge index; monitor checks every output change.
module tb_laser_pulse_guard_mc;
  localparam int NCH   = 4;
  localparam int CNT_W = 24;
  localparam int SS    = 2;
  localparam int D     = SS + 1;
  localparam int LO    = 10;
  localparam int HI    = 100;
  localparam int PLO   = 1000;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NCH-1:0]   laser_pulse = '0;
  logic [NCH-1:0]   chan_enable = '1;
  logic [NCH-1:0]   clear_fail = '0;
  logic [CNT_W-1:0] width_lo_limit = CNT_W'(LO);
  logic [CNT_W-1:0] width_hi_limit = CNT_W'(HI);
  logic [CNT_W-1:0] period_lo_limit = CNT_W'(PLO);
  logic [NCH-1:0]   pulse_lower_fail;
  logic [NCH-1:0]   pulse_upper_fail;
  logic [NCH-1:0]   rate_fail;
  logic             shutdown;
  logic [7:0]       fail_event_cnt;

  laser_pulse_guard_mc #(.NCH(NCH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rstn(rstn), .laser_pulse(laser_pulse), .chan_enable(chan_enable),
    .clear_fail(clear_fail), .width_lo_limit(width_lo_limit), .width_hi_limit(width_hi_limit),
    .period_lo_limit(period_lo_limit), .pulse_lower_fail(pulse_lower_fail),
    .pulse_upper_fail(pulse_upper_fail), .rate_fail(rate_fail), .shutdown(shutdown),
    .fail_event_cnt(fail_event_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          at;
    logic [20:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic        mon_en = 1'b0;
  logic [20:0] snap;
  logic [20:0] prev = '0;
  exp_t        cur_exp;

  logic [NCH-1:0] m_lower = '0;
  logic [NCH-1:0] m_upper = '0;
  logic [NCH-1:0] m_rate = '0;
  logic           m_sd = 1'b0;
  int             m_cnt = 0;

  assign snap = {pulse_lower_fail, pulse_upper_fail, rate_fail, shutdown, fail_event_cnt};

  function automatic logic [20:0] model_snap();
    return {m_lower, m_upper, m_rate, m_sd, 8'(m_cnt)};
  endfunction

  task automatic push(input string name, input int at);
    exp_q.push_back('{name, at, model_snap()});
  endtask

  task automatic exp_set(input string name, input logic [NCH-1:0] lm, input logic [NCH-1:0] um,
                         input logic [NCH-1:0] rm, input int at);
    logic [3*NCH-1:0] old_f;
    logic [3*NCH-1:0] new_f;
    old_f   = {m_lower, m_upper, m_rate};
    m_lower = m_lower | lm;
    m_upper = m_upper | um;
    m_rate  = m_rate | rm;
    new_f   = {m_lower, m_upper, m_rate};
    m_cnt   = m_cnt + $countones(new_f & ~old_f);
    if (m_cnt > 255) m_cnt = 255;
    push(name, at);
    if (!m_sd && (|new_f)) begin
      m_sd = 1'b1;
      push({name, "_shutdown"}, at + 1);
    end
  endtask

  task automatic exp_clear(input string name, input logic [NCH-1:0] cm, input int at);
    logic [3*NCH-1:0] old_f;
    old_f   = {m_lower, m_upper, m_rate};
    m_lower = m_lower & ~cm;
    m_upper = m_upper & ~cm;
    m_rate  = m_rate & ~cm;
    if ({m_lower, m_upper, m_rate} != old_f) push(name, at);
    if (m_sd && !(|{m_lower, m_upper, m_rate})) begin
      m_sd = 1'b0;
      push({name, "_shutdown"}, at + 1);
    end
  endtask

  task automatic chk_val(input string name, input logic [20:0] got, input logic [20:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (mon_en && (snap !== prev)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_change: got %h at cycle %0d, expected it to stay %h", snap, cyc, prev);
      end else begin
        cur_exp = exp_q.pop_front();
        if (snap === cur_exp.val && cyc == cur_exp.at) n_pass++;
        else $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
                      cur_exp.name, snap, cyc, cur_exp.val, cur_exp.at);
      end
      prev = snap;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int ch, input int w, input int gap);
    laser_pulse[ch] = 1'b1;
    tick(w);
    laser_pulse[ch] = 1'b0;
    tick(gap);
  endtask

  task automatic do_clear(input string name, input logic [NCH-1:0] cm);
    exp_clear(name, cm, cyc + 1);
    clear_fail = cm;
    tick(1);
    clear_fail = '0;
  endtask

  initial begin
    #3000000;
    n_checks++;
    $display("FAIL timeout: got no end of stimulus by cycle %0d, expected one well before", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    int e;
    tick(4);
    mon_en = 1'b1;
    chk_val("reset_state", snap, '0);
    rstn = 1'b1;
    tick(4);

    // ch0: five legal pulses, 50 high every 2000
    for (int k = 0; k < 5; k++) pulse(0, 50, 1950);

    // ch1: 10 high passes, 9 high trips the lower check on the fall
    pulse(1, 10, 1190);
    e = cyc;
    exp_set("ch1_lower", 4'b0010, '0, '0, e + 9 + D);
    pulse(1, 9, 1191);
    do_clear("ch1_clear", 4'b0010);

    // ch2: 100 high passes, a 150-high pulse trips upper on the 101st high cycle
    pulse(2, 100, 1100);
    e = cyc;
    exp_set("ch2_upper", '0, 4'b0100, '0, e + HI + D);
    pulse(2, 150, 1050);
    do_clear("ch2_clear", 4'b0100);

    // ch3: rises 999 apart trip rate, 1000 apart pass
    pulse(3, 20, 979);
    e = cyc;
    exp_set("ch3_rate", '0, '0, 4'b1000, e + D);
    laser_pulse[3] = 1'b1;
    tick(20);
    laser_pulse[3] = 1'b0;
    tick(10);
    do_clear("ch3_clear", 4'b1000);
    tick(969);
    pulse(3, 20, 1180);

    // ch1: fault in the same cycle as clear keeps the flag; clear alone drops it
    e = cyc;
    exp_set("ch1_lower2", 4'b0010, '0, '0, e + 9 + D);
    pulse(1, 9, 1191);
    laser_pulse[1] = 1'b1;
    tick(9);
    laser_pulse[1] = 1'b0;
    tick(2);
    clear_fail = 4'b0010;
    tick(1);
    clear_fail = '0;
    tick(1188);
    do_clear("ch1_clear2", 4'b0010);

    // ch0 and ch1 fail together: event count +2 in one cycle
    e = cyc;
    exp_set("ch01_lower", 4'b0011, '0, '0, e + 9 + D);
    laser_pulse[1:0] = 2'b11;
    tick(9);
    laser_pulse[1:0] = 2'b00;
    tick(1191);
    do_clear("ch01_clear", 4'b0011);

    // ch2 disabled mid-pulse: no flags; first rise after re-enable is not rate-checked
    laser_pulse[2] = 1'b1;
    tick(50);
    chan_enable[2] = 1'b0;
    tick(100);
    laser_pulse[2] = 1'b0;
    tick(20);
    chan_enable[2] = 1'b1;
    tick(20);
    pulse(2, 50, 1150);

    // reset mid-pulse on ch3 with a flag pending: everything clears, fresh rise is unchecked
    e = cyc;
    exp_set("ch0_lower_pre_reset", 4'b0001, '0, '0, e + 9 + D);
    pulse(0, 9, 100);
    laser_pulse[3] = 1'b1;
    tick(30);
    m_lower = '0;
    m_upper = '0;
    m_rate  = '0;
    m_sd    = 1'b0;
    m_cnt   = 0;
    push("reset_mid_pulse", cyc);
    rstn = 1'b0;
    tick(5);
    rstn = 1'b1;
    tick(50);
    laser_pulse[3] = 1'b0;
    tick(200);

    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL queue_drained: got %0d pending expectations, expected 0", exp_q.size());
    chk_val("final_state", snap, model_snap());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
